// File: rtl/rs_multi_cdb_if.sv
// Issue, result-broadcast and ALU-dispatch signal bundle for the reservation station.
// The master side drives issue/CDB/control; the slave side is the station itself.
interface rs_multi_cdb_if #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ROB_W   = 4,
    parameter int unsigned OP_W    = 6,
    parameter int unsigned NUM_CDB = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                     rdy_in;
    logic                     clr_in;

    logic                     issue_valid;
    logic [ROB_W-1:0]         issue_rob_index;
    logic [OP_W-1:0]          issue_op;
    logic [XLEN-1:0]          issue_rs1_val;
    logic [XLEN-1:0]          issue_rs2_val;
    logic [ROB_W-1:0]         issue_rs1_depend;
    logic [ROB_W-1:0]         issue_rs2_depend;
    logic [XLEN-1:0]          issue_imm;
    logic [XLEN-1:0]          issue_PC;

    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*ROB_W-1:0] cdb_rob_index;
    logic [NUM_CDB*XLEN-1:0]  cdb_result;

    logic                     alu_stall;
    logic                     rs_to_alu_ready;
    logic [OP_W-1:0]          rs_to_alu_op;
    logic [XLEN-1:0]          rs_to_alu_rs1;
    logic [XLEN-1:0]          rs_to_alu_rs2;
    logic [ROB_W-1:0]         rs_to_alu_rob_index;
    logic [XLEN-1:0]          rs_to_alu_PC;
    logic [XLEN-1:0]          rs_to_alu_imm;

    logic                     rs_full;
    logic                     rs_almost_full;
    logic [CNT_W-1:0]         rs_count;

    modport master (
        output rdy_in, clr_in,
        output issue_valid, issue_rob_index, issue_op, issue_rs1_val, issue_rs2_val,
        output issue_rs1_depend, issue_rs2_depend, issue_imm, issue_PC,
        output cdb_valid, cdb_rob_index, cdb_result,
        output alu_stall,
        input  rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2,
        input  rs_to_alu_rob_index, rs_to_alu_PC, rs_to_alu_imm,
        input  rs_full, rs_almost_full, rs_count
    );

    modport slave (
        input  rdy_in, clr_in,
        input  issue_valid, issue_rob_index, issue_op, issue_rs1_val, issue_rs2_val,
        input  issue_rs1_depend, issue_rs2_depend, issue_imm, issue_PC,
        input  cdb_valid, cdb_rob_index, cdb_result,
        input  alu_stall,
        output rs_to_alu_ready, rs_to_alu_op, rs_to_alu_rs1, rs_to_alu_rs2,
        output rs_to_alu_rob_index, rs_to_alu_PC, rs_to_alu_imm,
        output rs_full, rs_almost_full, rs_count
    );
endinterface

// File: rtl/rs_multi_cdb.sv
// ALU reservation station: multi-channel CDB operand capture, age-ordered select and a
// valid/stall dispatch register towards the ALU.
module rs_multi_cdb #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ROB_W   = 4,
    parameter int unsigned OP_W    = 6,
    parameter int unsigned NUM_CDB = 2
) (
    input logic           clk_in,
    input logic           rst_n_in,
    rs_multi_cdb_if.slave rs_if
);

    localparam int          NEnt  = int'(DEPTH);
    localparam int          NCdb  = int'(NUM_CDB);
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned IdxW  = $clog2(DEPTH);

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [ROB_W-1:0] rob;
        logic [XLEN-1:0]  v1;
        logic [XLEN-1:0]  v2;
        logic [ROB_W-1:0] d1;
        logic [ROB_W-1:0] d2;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
    } entry_t;

    logic [DEPTH-1:0] busy_q, busy_d;
    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    // age_q[i][j] set means entry i was allocated before entry j
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];
    logic [CntW-1:0]  count_q, count_d;
    logic             out_vld_q, out_vld_d;
    entry_t           out_q, out_d;

    logic             rs_full_w;
    logic             accept;
    logic             load;
    logic             any_ready;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] sel_oh;
    logic [IdxW-1:0]  sel_idx;
    logic [IdxW-1:0]  alloc_idx;
    logic [XLEN:0]    byp1, byp2;
    logic [XLEN:0]    wk1 [DEPTH];
    logic [XLEN:0]    wk2 [DEPTH];
    entry_t           new_ent;

    // Returns {hit, value}; tag 0 never hits and the lowest matching channel wins.
    function automatic logic [XLEN:0] snoop(
        input logic [ROB_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       vld,
        input logic [NUM_CDB*ROB_W-1:0] tags,
        input logic [NUM_CDB*XLEN-1:0]  res
    );
        logic [XLEN:0] r;
        r = '0;
        for (int k = NCdb - 1; k >= 0; k--) begin
            if (vld[k] && (tag != '0) && (tags[k*ROB_W +: ROB_W] == tag)) begin
                r = {1'b1, res[k*XLEN +: XLEN]};
            end
        end
        return r;
    endfunction

    assign rs_full_w = (count_q == CntW'(DEPTH));
    assign accept    = rs_if.issue_valid && !rs_full_w;
    assign load      = any_ready && (!out_vld_q || !rs_if.alu_stall);

    always_comb begin
        alloc_idx = '0;
        for (int i = NEnt - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                alloc_idx = IdxW'(i);
            end
        end
    end

    always_comb begin
        ready = '0;
        for (int i = 0; i < NEnt; i++) begin
            ready[i] = busy_q[i] && (ent_q[i].d1 == '0) && (ent_q[i].d2 == '0);
        end
    end

    // Oldest ready entry: ready and no other ready entry is older than it.
    always_comb begin
        sel_oh  = '0;
        sel_idx = '0;
        for (int i = 0; i < NEnt; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < NEnt; j++) begin
                if (ready[j] && age_q[j][i]) begin
                    blocked = 1'b1;
                end
            end
            sel_oh[i] = ready[i] && !blocked;
        end
        for (int i = 0; i < NEnt; i++) begin
            if (sel_oh[i]) begin
                sel_idx = IdxW'(i);
            end
        end
    end

    assign any_ready = |ready;

    always_comb begin
        byp1 = snoop(rs_if.issue_rs1_depend, rs_if.cdb_valid, rs_if.cdb_rob_index,
                     rs_if.cdb_result);
        byp2 = snoop(rs_if.issue_rs2_depend, rs_if.cdb_valid, rs_if.cdb_rob_index,
                     rs_if.cdb_result);
        for (int i = 0; i < NEnt; i++) begin
            wk1[i] = snoop(ent_q[i].d1, rs_if.cdb_valid, rs_if.cdb_rob_index,
                           rs_if.cdb_result);
            wk2[i] = snoop(ent_q[i].d2, rs_if.cdb_valid, rs_if.cdb_rob_index,
                           rs_if.cdb_result);
        end
    end

    always_comb begin
        new_ent     = '0;
        new_ent.op  = rs_if.issue_op;
        new_ent.rob = rs_if.issue_rob_index;
        new_ent.imm = rs_if.issue_imm;
        new_ent.pc  = rs_if.issue_PC;
        new_ent.v1  = byp1[XLEN] ? byp1[XLEN-1:0] : rs_if.issue_rs1_val;
        new_ent.d1  = byp1[XLEN] ? '0 : rs_if.issue_rs1_depend;
        new_ent.v2  = byp2[XLEN] ? byp2[XLEN-1:0] : rs_if.issue_rs2_val;
        new_ent.d2  = byp2[XLEN] ? '0 : rs_if.issue_rs2_depend;
    end

    always_comb begin
        busy_d    = busy_q;
        count_d   = count_q;
        out_vld_d = out_vld_q;
        out_d     = out_q;
        for (int i = 0; i < NEnt; i++) begin
            ent_d[i] = ent_q[i];
            age_d[i] = age_q[i];
        end

        if (rs_if.clr_in) begin
            busy_d    = '0;
            count_d   = '0;
            out_vld_d = 1'b0;
        end else if (rs_if.rdy_in) begin
            for (int i = 0; i < NEnt; i++) begin
                if (busy_q[i] && wk1[i][XLEN]) begin
                    ent_d[i].v1 = wk1[i][XLEN-1:0];
                    ent_d[i].d1 = '0;
                end
                if (busy_q[i] && wk2[i][XLEN]) begin
                    ent_d[i].v2 = wk2[i][XLEN-1:0];
                    ent_d[i].d2 = '0;
                end
            end

            if (load) begin
                out_d           = ent_q[sel_idx];
                out_vld_d       = 1'b1;
                busy_d[sel_idx] = 1'b0;
            end else if (out_vld_q && !rs_if.alu_stall) begin
                out_vld_d = 1'b0;
            end

            // Allocation only looks at start-of-cycle busy bits, so a slot freed by
            // this cycle's dispatch is never reused until the next cycle.
            if (accept) begin
                ent_d[alloc_idx]  = new_ent;
                busy_d[alloc_idx] = 1'b1;
                age_d[alloc_idx]  = '0;
                for (int j = 0; j < NEnt; j++) begin
                    if (busy_q[j]) begin
                        age_d[j][alloc_idx] = 1'b1;
                    end
                end
            end

            count_d = count_q + CntW'(accept) - CntW'(load);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q    <= '0;
            count_q   <= '0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
            for (int i = 0; i < NEnt; i++) begin
                ent_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            busy_q    <= busy_d;
            count_q   <= count_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
            for (int i = 0; i < NEnt; i++) begin
                ent_q[i] <= ent_d[i];
                age_q[i] <= age_d[i];
            end
        end
    end

    assign rs_if.rs_to_alu_ready     = out_vld_q;
    assign rs_if.rs_to_alu_op        = out_q.op;
    assign rs_if.rs_to_alu_rs1       = out_q.v1;
    assign rs_if.rs_to_alu_rs2       = out_q.v2;
    assign rs_if.rs_to_alu_rob_index = out_q.rob;
    assign rs_if.rs_to_alu_PC        = out_q.pc;
    assign rs_if.rs_to_alu_imm       = out_q.imm;
    assign rs_if.rs_full             = rs_full_w;
    assign rs_if.rs_almost_full      = (count_q >= CntW'(DEPTH - 1));
    assign rs_if.rs_count            = count_q;

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Directed bench for rs_multi_cdb (DEPTH=4, two CDB channels) with hand-computed
// expectations.
module tb_rs_multi_cdb;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned ROB_W   = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned NUM_CDB = 2;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    int   n_cmp    = 0;
    int   n_err    = 0;

    always #5 clk_in = ~clk_in;

    rs_multi_cdb_if #(
        .DEPTH(DEPTH), .XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)
    ) rs_if ();

    rs_multi_cdb #(
        .DEPTH(DEPTH), .XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rs_if    (rs_if)
    );

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rs_if.issue_valid      = 1'b0;
        rs_if.issue_rob_index  = '0;
        rs_if.issue_op         = '0;
        rs_if.issue_rs1_val    = '0;
        rs_if.issue_rs2_val    = '0;
        rs_if.issue_rs1_depend = '0;
        rs_if.issue_rs2_depend = '0;
        rs_if.issue_imm        = '0;
        rs_if.issue_PC         = '0;
        rs_if.cdb_valid        = '0;
        rs_if.cdb_rob_index    = '0;
        rs_if.cdb_result       = '0;
    endtask

    // imm and PC are derived from the rob tag so every dispatch is distinguishable.
    task automatic drive_issue(input logic [3:0] rob, input logic [5:0] op,
                               input logic [31:0] v1, input logic [31:0] v2,
                               input logic [3:0] d1, input logic [3:0] d2);
        rs_if.issue_valid      = 1'b1;
        rs_if.issue_rob_index  = rob;
        rs_if.issue_op         = op;
        rs_if.issue_rs1_val    = v1;
        rs_if.issue_rs2_val    = v2;
        rs_if.issue_rs1_depend = d1;
        rs_if.issue_rs2_depend = d2;
        rs_if.issue_imm        = 32'h1000 + 32'(rob);
        rs_if.issue_PC         = 32'h8000_0000 + 32'(rob) * 4;
    endtask

    task automatic drive_cdb(input int ch, input logic [3:0] tag, input logic [31:0] val);
        rs_if.cdb_valid[ch]                    = 1'b1;
        rs_if.cdb_rob_index[ch*ROB_W +: ROB_W] = tag;
        rs_if.cdb_result[ch*XLEN +: XLEN]      = val;
    endtask

    task automatic check_out(input string tag, input logic [3:0] rob,
                             input logic [31:0] v1, input logic [31:0] v2);
        check_eq({tag, ".ready"}, 64'(rs_if.rs_to_alu_ready), 64'd1);
        check_eq({tag, ".rob"}, 64'(rs_if.rs_to_alu_rob_index), 64'(rob));
        check_eq({tag, ".rs1"}, 64'(rs_if.rs_to_alu_rs1), 64'(v1));
        check_eq({tag, ".rs2"}, 64'(rs_if.rs_to_alu_rs2), 64'(v2));
    endtask

    task automatic check_state(input string tag, input logic rdy, input int cnt);
        check_eq({tag, ".ready"}, 64'(rs_if.rs_to_alu_ready), 64'(rdy));
        check_eq({tag, ".count"}, 64'(rs_if.rs_count), 64'(cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rs_if.rdy_in    = 1'b1;
        rs_if.clr_in    = 1'b0;
        rs_if.alu_stall = 1'b0;
        idle();

        // Reset
        tick();
        tick();
        check_state("rst", 1'b0, 0);
        check_eq("rst.full", 64'(rs_if.rs_full), 64'd0);
        check_eq("rst.afull", 64'(rs_if.rs_almost_full), 64'd0);
        check_eq("rst.rob", 64'(rs_if.rs_to_alu_rob_index), 64'd0);
        check_eq("rst.pc", 64'(rs_if.rs_to_alu_PC), 64'd0);
        rst_n_in = 1'b1;

        // Ready operands: visible two cycles after issue
        drive_issue(4'd3, 6'd1, 32'd5, 32'd7, 4'd0, 4'd0);
        tick();
        idle();
        check_state("basic.c1", 1'b0, 1);
        tick();
        check_out("basic", 4'd3, 32'd5, 32'd7);
        check_eq("basic.op", 64'(rs_if.rs_to_alu_op), 64'd1);
        check_eq("basic.imm", 64'(rs_if.rs_to_alu_imm), 64'h1003);
        check_eq("basic.pc", 64'(rs_if.rs_to_alu_PC), 64'h8000_000c);
        check_eq("basic.count", 64'(rs_if.rs_count), 64'd0);
        tick();
        check_eq("basic.drop", 64'(rs_if.rs_to_alu_ready), 64'd0);

        // Wakeup from channel 1
        drive_issue(4'd2, 6'd2, 32'h99, 32'd1, 4'd5, 4'd0);
        tick();
        idle();
        tick();
        check_state("wake.wait", 1'b0, 1);
        drive_cdb(1, 4'd5, 32'hDEAD);
        tick();
        idle();
        check_eq("wake.c1", 64'(rs_if.rs_to_alu_ready), 64'd0);
        tick();
        check_out("wake", 4'd2, 32'hDEAD, 32'd1);
        tick();
        check_state("wake.end", 1'b0, 0);

        // Issue-cycle bypass, both channels match: channel 0 wins
        drive_issue(4'd4, 6'd3, 32'h55, 32'h77, 4'd0, 4'd6);
        drive_cdb(0, 4'd6, 32'h11);
        drive_cdb(1, 4'd6, 32'h22);
        tick();
        idle();
        check_eq("byp.count", 64'(rs_if.rs_count), 64'd1);
        tick();
        check_out("byp", 4'd4, 32'h55, 32'h11);
        tick();
        check_state("byp.end", 1'b0, 0);

        // Fill: output register parked on rob 9 under stall, then four issues
        rs_if.alu_stall = 1'b1;
        drive_issue(4'd9, 6'd4, 32'h90, 32'h91, 4'd0, 4'd0);
        tick();
        idle();
        tick();
        check_out("park", 4'd9, 32'h90, 32'h91);
        drive_issue(4'd1, 6'd5, 32'h0, 32'h12, 4'd7, 4'd0);
        tick();
        drive_issue(4'd2, 6'd5, 32'h20, 32'h21, 4'd0, 4'd0);
        tick();
        drive_issue(4'd3, 6'd5, 32'h30, 32'h31, 4'd0, 4'd0);
        tick();
        check_eq("fill3.count", 64'(rs_if.rs_count), 64'd3);
        check_eq("fill3.afull", 64'(rs_if.rs_almost_full), 64'd1);
        check_eq("fill3.full", 64'(rs_if.rs_full), 64'd0);
        drive_issue(4'd4, 6'd5, 32'h40, 32'h41, 4'd0, 4'd0);
        tick();
        check_eq("fill4.full", 64'(rs_if.rs_full), 64'd1);
        drive_issue(4'd5, 6'd5, 32'h50, 32'h51, 4'd0, 4'd0);
        tick();
        idle();
        check_eq("drop5.count", 64'(rs_if.rs_count), 64'd4);
        check_eq("drop5.rob", 64'(rs_if.rs_to_alu_rob_index), 64'd9);
        rs_if.alu_stall = 1'b0;
        tick();
        check_out("ord.2", 4'd2, 32'h20, 32'h21);
        check_eq("ord.2.count", 64'(rs_if.rs_count), 64'd3);
        tick();
        check_out("ord.3", 4'd3, 32'h30, 32'h31);
        tick();
        check_out("ord.4", 4'd4, 32'h40, 32'h41);
        tick();
        check_state("ord.wait1", 1'b0, 1);
        drive_cdb(0, 4'd7, 32'h70);
        tick();
        idle();
        tick();
        check_out("ord.1", 4'd1, 32'h70, 32'h12);
        tick();
        check_state("ord.end", 1'b0, 0);
        tick();
        check_eq("ord.no5", 64'(rs_if.rs_to_alu_ready), 64'd0);

        // Stall; rob 12 reuses the lower slot but is younger than rob 11
        rs_if.alu_stall = 1'b1;
        drive_issue(4'd10, 6'd6, 32'hA0, 32'hA1, 4'd0, 4'd0);
        tick();
        drive_issue(4'd11, 6'd6, 32'hB0, 32'hB1, 4'd0, 4'd0);
        tick();
        drive_issue(4'd12, 6'd6, 32'hC0, 32'hC1, 4'd0, 4'd0);
        tick();
        idle();
        for (int s = 0; s < 3; s++) begin
            check_out("stall.hold", 4'd10, 32'hA0, 32'hA1);
            check_eq("stall.count", 64'(rs_if.rs_count), 64'd2);
            if (s < 2) tick();
        end
        rs_if.alu_stall = 1'b0;
        tick();
        check_out("stall.11", 4'd11, 32'hB0, 32'hB1);
        tick();
        check_out("stall.12", 4'd12, 32'hC0, 32'hC1);
        tick();
        check_state("stall.end", 1'b0, 0);

        // Flush with three waiting entries and a parked output
        rs_if.alu_stall = 1'b1;
        drive_issue(4'd14, 6'd7, 32'hE0, 32'hE1, 4'd0, 4'd0);
        tick();
        drive_issue(4'd15, 6'd7, 32'h0, 32'h0, 4'd9, 4'd0);
        tick();
        drive_issue(4'd7, 6'd7, 32'h0, 32'h0, 4'd9, 4'd0);
        tick();
        drive_issue(4'd6, 6'd7, 32'h0, 32'h0, 4'd9, 4'd0);
        tick();
        idle();
        check_state("pre.clr", 1'b1, 3);
        rs_if.clr_in = 1'b1;
        drive_issue(4'd13, 6'd7, 32'hD0, 32'hD1, 4'd0, 4'd0);
        drive_cdb(0, 4'd9, 32'h99);
        tick();
        rs_if.clr_in = 1'b0;
        idle();
        check_state("clr", 1'b0, 0);
        rs_if.alu_stall = 1'b0;
        drive_cdb(0, 4'd9, 32'h99);
        tick();
        idle();
        tick();
        check_state("clr.gone", 1'b0, 0);

        // rdy_in low: issue ignored
        rs_if.rdy_in = 1'b0;
        drive_issue(4'd8, 6'd8, 32'h80, 32'h81, 4'd0, 4'd0);
        tick();
        tick();
        check_state("rdy0", 1'b0, 0);
        rs_if.rdy_in = 1'b1;
        tick();
        idle();
        tick();
        check_out("rdy1", 4'd8, 32'h80, 32'h81);
        // rdy_in low also holds a valid output that would otherwise drain
        rs_if.rdy_in = 1'b0;
        tick();
        check_eq("rdy0.hold", 64'(rs_if.rs_to_alu_ready), 64'd1);
        rs_if.rdy_in = 1'b1;

        // Asynchronous reset mid-stall
        rs_if.alu_stall = 1'b1;
        drive_issue(4'd5, 6'd9, 32'h5A, 32'h5B, 4'd3, 4'd0);
        tick();
        idle();
        rst_n_in = 1'b0;
        #1;
        check_state("arst", 1'b0, 0);
        check_eq("arst.rob", 64'(rs_if.rs_to_alu_rob_index), 64'd0);
        check_eq("arst.rs1", 64'(rs_if.rs_to_alu_rs1), 64'd0);
        rst_n_in = 1'b1;
        rs_if.alu_stall = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
